// File: rtl/edp_fm_arb_pkg.sv
// Shared types and sizes for the EDP fast-memory arbiter.
// Sources, diag states and FM geometry.
package edp_fm_arb_pkg;

  localparam int FM_WORDS = 128;
  localparam int FM_AW    = 7;
  localparam int LANES    = 6;

  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_CP    = 2'd1,
    SRC_DIAG  = 2'd2,
    SRC_SCRUB = 2'd3
  } fm_src_t;

  typedef enum logic [2:0] {
    D_IDLE,
    D_ISSUE,
    D_WAIT,
    D_ACK,
    D_DONE
  } diag_st_t;

endpackage

// File: rtl/edp_fm_par.sv
// Per-lane odd parity: with par_in = 0 it generates parity,
// with par_in = stored parity a 1 marks a failing lane.
module edp_fm_par #(
  parameter int WORD_W = 36,
  parameter int LANE_W = 6
) (
  input  logic [WORD_W-1:0]        data,
  input  logic [WORD_W/LANE_W-1:0] par_in,
  output logic [WORD_W/LANE_W-1:0] lane_par
);

  always_comb begin
    lane_par = '0;
    for (int i = 0; i < WORD_W / LANE_W; i++) begin
      lane_par[i] = ~^{data[i*LANE_W +: LANE_W], par_in[i]};
    end
  end

endmodule

// File: rtl/edp_fm_arb.sv
// EDP fast-memory port arbiter: CP > diag > scrub, with
// write parity generation and first-error capture on reads.
module edp_fm_arb
  import edp_fm_arb_pkg::*;
#(
  parameter int WORD_W    = 36,
  parameter int LANE_W    = 6,
  parameter int SCRUB_GAP = 16
) (
  input  logic              clk_h,
  input  logic              reset_h,
  input  logic [2:0]        cp_fm_block,
  input  logic [3:0]        cp_fm_adr,
  input  logic              cp_fm_write_h,
  input  logic              cp_fm_read_h,
  input  logic [WORD_W-1:0] cp_wdata,
  input  logic              diag_req_h,
  input  logic              diag_write_h,
  input  logic [6:0]        diag_addr,
  input  logic [WORD_W-1:0] diag_wdata,
  output logic              diag_ack_h,
  output logic [WORD_W-1:0] diag_rdata,
  input  logic              scrub_en_h,
  input  logic              err_clr_h,
  output logic [6:0]        fm_addr,
  output logic              fm_we_h,
  output logic [WORD_W-1:0] fm_wdata,
  output logic [5:0]        fm_wpar,
  input  logic [WORD_W-1:0] fm_rdata,
  input  logic [5:0]        fm_rpar,
  output logic [WORD_W-1:0] cp_rdata,
  output logic              err_valid_h,
  output logic [6:0]        err_addr,
  output logic [1:0]        err_src,
  output logic [5:0]        err_lanes
);

  localparam logic [7:0] GAP = 8'(SCRUB_GAP);

  fm_src_t           src;
  fm_src_t           chk_src;
  diag_st_t          st;
  diag_st_t          st_nx;
  logic [6:0]        addr_q;
  logic [6:0]        chk_addr;
  logic [6:0]        dg_addr;
  logic [6:0]        scr_ptr;
  logic              dg_write;
  logic [WORD_W-1:0] dg_wdata;
  logic [7:0]        gap;
  logic [5:0]        wpar_raw;
  logic [5:0]        rfail;
  logic              err_hit;

  always_comb begin
    src      = SRC_NONE;
    fm_we_h  = 1'b0;
    fm_addr  = addr_q;
    fm_wdata = '0;
    if (cp_fm_write_h) begin
      src      = SRC_CP;
      fm_we_h  = 1'b1;
      fm_addr  = {cp_fm_block, cp_fm_adr};
      fm_wdata = cp_wdata;
    end else if (cp_fm_read_h) begin
      src     = SRC_CP;
      fm_addr = {cp_fm_block, cp_fm_adr};
    end else if (st == D_ISSUE) begin
      src      = SRC_DIAG;
      fm_we_h  = dg_write;
      fm_addr  = dg_addr;
      fm_wdata = dg_write ? dg_wdata : '0;
    end else if (scrub_en_h && gap == GAP) begin
      src     = SRC_SCRUB;
      fm_addr = scr_ptr;
    end
  end

  edp_fm_par #(
    .WORD_W(WORD_W),
    .LANE_W(LANE_W)
  ) u_wpar (
    .data    (fm_wdata),
    .par_in  ('0),
    .lane_par(wpar_raw)
  );

  edp_fm_par #(
    .WORD_W(WORD_W),
    .LANE_W(LANE_W)
  ) u_rchk (
    .data    (fm_rdata),
    .par_in  (fm_rpar),
    .lane_par(rfail)
  );

  assign fm_wpar    = fm_we_h ? wpar_raw : '0;
  assign err_hit    = (chk_src != SRC_NONE) && (|rfail);
  assign diag_ack_h = (st == D_ACK);

  // DONE waits for req to drop so a held request runs once
  always_comb begin
    st_nx = st;
    case (st)
      D_IDLE:  if (diag_req_h) st_nx = D_ISSUE;
      D_ISSUE: if (src == SRC_DIAG) st_nx = dg_write ? D_ACK : D_WAIT;
      D_WAIT:  st_nx = D_ACK;
      D_ACK:   st_nx = D_DONE;
      D_DONE:  if (!diag_req_h) st_nx = D_IDLE;
      default: st_nx = D_IDLE;
    endcase
  end

  always_ff @(posedge clk_h) begin
    if (reset_h) begin
      st         <= D_IDLE;
      addr_q     <= '0;
      chk_addr   <= '0;
      chk_src    <= SRC_NONE;
      dg_write   <= 1'b0;
      dg_addr    <= '0;
      dg_wdata   <= '0;
      diag_rdata <= '0;
      cp_rdata   <= '0;
    end else begin
      st       <= st_nx;
      addr_q   <= fm_addr;
      chk_addr <= fm_addr;
      chk_src  <= fm_we_h ? SRC_NONE : src;
      if (st == D_IDLE && diag_req_h) begin
        dg_write <= diag_write_h;
        dg_addr  <= diag_addr;
        dg_wdata <= diag_wdata;
      end
      if (st == D_WAIT) diag_rdata <= fm_rdata;
      if (chk_src == SRC_CP) cp_rdata <= fm_rdata;
    end
  end

  always_ff @(posedge clk_h) begin
    if (reset_h) begin
      scr_ptr <= '0;
      gap     <= '0;
    end else if (!scrub_en_h) begin
      gap <= '0;
    end else if (src == SRC_SCRUB) begin
      scr_ptr <= scr_ptr + 7'd1;
      gap     <= '0;
    end else if (src == SRC_NONE && gap != GAP) begin
      gap <= gap + 8'd1;
    end
  end

  // a clear in the same cycle as a new error still captures it
  always_ff @(posedge clk_h) begin
    if (reset_h) begin
      err_valid_h <= 1'b0;
      err_addr    <= '0;
      err_src     <= '0;
      err_lanes   <= '0;
    end else if (err_hit && (!err_valid_h || err_clr_h)) begin
      err_valid_h <= 1'b1;
      err_addr    <= chk_addr;
      err_src     <= chk_src;
      err_lanes   <= rfail;
    end else if (err_clr_h) begin
      err_valid_h <= 1'b0;
      err_addr    <= '0;
      err_src     <= '0;
      err_lanes   <= '0;
    end
  end

endmodule

// File: tb/tb_edp_fm_arb.sv
// Randomized scoreboard bench for edp_fm_arb with a RAM model
// and an abstract per-cycle reference of the arbitration rules.
module tb_edp_fm_arb;
  import edp_fm_arb_pkg::*;

  localparam int GAP = 4;

  logic clk_h = 1'b0;
  always #5 clk_h = ~clk_h;

  logic        reset_h;
  logic [2:0]  cp_fm_block;
  logic [3:0]  cp_fm_adr;
  logic        cp_fm_write_h, cp_fm_read_h;
  logic [35:0] cp_wdata;
  logic        diag_req_h, diag_write_h;
  logic [6:0]  diag_addr;
  logic [35:0] diag_wdata;
  logic        diag_ack_h;
  logic [35:0] diag_rdata;
  logic        scrub_en_h, err_clr_h;
  logic [6:0]  fm_addr;
  logic        fm_we_h;
  logic [35:0] fm_wdata;
  logic [5:0]  fm_wpar;
  logic [35:0] fm_rdata;
  logic [5:0]  fm_rpar;
  logic [35:0] cp_rdata;
  logic        err_valid_h;
  logic [6:0]  err_addr;
  logic [1:0]  err_src;
  logic [5:0]  err_lanes;

  edp_fm_arb #(.SCRUB_GAP(GAP)) dut (
    .clk_h(clk_h), .reset_h(reset_h),
    .cp_fm_block(cp_fm_block), .cp_fm_adr(cp_fm_adr),
    .cp_fm_write_h(cp_fm_write_h), .cp_fm_read_h(cp_fm_read_h),
    .cp_wdata(cp_wdata),
    .diag_req_h(diag_req_h), .diag_write_h(diag_write_h),
    .diag_addr(diag_addr), .diag_wdata(diag_wdata),
    .diag_ack_h(diag_ack_h), .diag_rdata(diag_rdata),
    .scrub_en_h(scrub_en_h), .err_clr_h(err_clr_h),
    .fm_addr(fm_addr), .fm_we_h(fm_we_h),
    .fm_wdata(fm_wdata), .fm_wpar(fm_wpar),
    .fm_rdata(fm_rdata), .fm_rpar(fm_rpar),
    .cp_rdata(cp_rdata), .err_valid_h(err_valid_h),
    .err_addr(err_addr), .err_src(err_src), .err_lanes(err_lanes)
  );

  function automatic logic [5:0] opar(input logic [35:0] d);
    logic [5:0] p;
    int c;
    for (int i = 0; i < 6; i++) begin
      c = 0;
      for (int b = 0; b < 6; b++) c += int'(d[6*i+b]);
      p[i] = (c % 2 == 0);
    end
    return p;
  endfunction

  // RAM: stores data plus a per-word parity error mask
  logic [35:0] mem_d[128];
  logic [5:0]  mem_bad[128];
  logic [35:0] rq_d;
  logic [5:0]  rq_bad;
  logic [5:0]  inj;
  logic        ram_init = 1'b1;

  always @(posedge clk_h) begin
    if (ram_init) begin
      for (int i = 0; i < 128; i++) begin
        mem_d[i]   <= '0;
        mem_bad[i] <= '0;
      end
      rq_d   <= '0;
      rq_bad <= '0;
    end else begin
      rq_d   <= mem_d[fm_addr];
      rq_bad <= mem_bad[fm_addr];
      if (fm_we_h) begin
        mem_d[fm_addr]   <= fm_wdata;
        mem_bad[fm_addr] <= fm_wpar ^ opar(fm_wdata);
      end
    end
  end

  assign fm_rdata = rq_d;
  assign fm_rpar  = opar(rq_d) ^ rq_bad ^ inj;

  typedef struct packed {
    logic        skip;
    logic        zero;
    logic [6:0]  addr;
    logic        we;
    logic [35:0] wd;
    logic [5:0]  wp;
    logic        ack;
    logic [35:0] drd;
    logic [35:0] cprd;
    logic        ev;
    logic [6:0]  ea;
    logic [1:0]  es;
    logic [5:0]  el;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // reference model state
  int          m_ph;
  logic        m_dw;
  logic [6:0]  m_da;
  logic [35:0] m_dd;
  int          m_ptr, m_gap, m_psrc;
  logic [6:0]  m_last, m_paddr;
  logic [35:0] m_cp, m_drd;
  logic        m_ev;
  logic [6:0]  m_ea;
  logic [1:0]  m_es;
  logic [5:0]  m_el;
  logic        m_after_rst;
  logic [35:0] shadow[128];

  // stimulus for the next cycle
  logic        s_rst, s_w, s_r, s_dreq, s_dw, s_sen, s_clr;
  logic [2:0]  s_blk;
  logic [3:0]  s_adr;
  logic [35:0] s_cwd, s_dwd;
  logic [6:0]  s_da;
  logic [5:0]  s_inj;

  task automatic model_reset();
    m_ph = 0; m_dw = 0; m_da = 0; m_dd = 0;
    m_ptr = 0; m_gap = 0; m_psrc = 0;
    m_last = 0; m_paddr = 0; m_cp = 0; m_drd = 0;
    m_ev = 0; m_ea = 0; m_es = 0; m_el = 0;
  endtask

  task automatic quiet();
    s_rst = 0; s_w = 0; s_r = 0; s_dreq = 0; s_dw = 0;
    s_clr = 0; s_inj = 0; s_blk = 0; s_adr = 0;
    s_cwd = 0; s_dwd = 0; s_da = 0;
  endtask

  task automatic step();
    exp_t e;
    int own;
    logic [6:0] a;
    logic we;
    logic [35:0] wd, rd;
    logic [5:0] fail;
    @(negedge clk_h);
    reset_h = s_rst;
    cp_fm_write_h = s_w; cp_fm_read_h = s_r;
    cp_fm_block = s_blk; cp_fm_adr = s_adr; cp_wdata = s_cwd;
    diag_req_h = s_dreq; diag_write_h = s_dw;
    diag_addr = s_da; diag_wdata = s_dwd;
    scrub_en_h = s_sen; err_clr_h = s_clr; inj = s_inj;
    e = '0;
    if (s_rst) begin
      e.skip = 1;
      q.push_back(e);
      model_reset();
      m_after_rst = 1;
      return;
    end
    own = 0; a = m_last; we = 0; wd = 0;
    if (s_w) begin
      own = 1; a = {s_blk, s_adr}; we = 1; wd = s_cwd;
    end else if (s_r) begin
      own = 1; a = {s_blk, s_adr};
    end else if (m_ph == 1) begin
      own = 2; a = m_da; we = m_dw; wd = m_dw ? m_dd : 0;
    end else if (s_sen && m_gap == GAP) begin
      own = 3; a = 7'(m_ptr);
    end
    e.zero = m_after_rst;
    e.addr = a; e.we = we; e.wd = wd;
    e.wp = we ? opar(wd) : 6'd0;
    e.ack = (m_ph == 3); e.drd = m_drd; e.cprd = m_cp;
    e.ev = m_ev; e.ea = m_ea; e.es = m_es; e.el = m_el;
    q.push_back(e);
    m_after_rst = 0;
    rd = shadow[m_paddr];
    fail = (m_psrc != 0) ? s_inj : 6'd0;
    if (m_psrc == 1) m_cp = rd;
    if (m_ph == 2) m_drd = rd;
    if (fail != 0 && (!m_ev || s_clr)) begin
      m_ev = 1; m_ea = m_paddr; m_es = 2'(m_psrc); m_el = fail;
    end else if (s_clr) begin
      m_ev = 0; m_ea = 0; m_es = 0; m_el = 0;
    end
    if (we) shadow[a] = wd;
    case (m_ph)
      0: if (s_dreq) begin
           m_ph = 1; m_dw = s_dw; m_da = s_da; m_dd = s_dwd;
         end
      1: if (own == 2) m_ph = m_dw ? 3 : 2;
      2: m_ph = 3;
      3: m_ph = 4;
      default: if (!s_dreq) m_ph = 0;
    endcase
    if (!s_sen) m_gap = 0;
    else if (own == 3) begin
      m_gap = 0; m_ptr = (m_ptr + 1) % 128;
    end else if (own == 0 && m_gap < GAP) m_gap++;
    m_psrc = (own != 0 && !we) ? own : 0;
    m_paddr = a;
    m_last = a;
  endtask

  task automatic chk(input string nm, input logic [35:0] act,
                     input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_h);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (!e.skip) begin
          chk("fm_addr", 36'(fm_addr), 36'(e.addr));
          chk("fm_we", 36'(fm_we_h), 36'(e.we));
          if (e.we || e.zero) begin
            chk("fm_wdata", fm_wdata, e.wd);
            chk("fm_wpar", 36'(fm_wpar), 36'(e.wp));
          end
          chk("diag_ack", 36'(diag_ack_h), 36'(e.ack));
          if (e.ack || e.zero) chk("diag_rdata", diag_rdata, e.drd);
          chk("cp_rdata", cp_rdata, e.cprd);
          chk("err_valid", 36'(err_valid_h), 36'(e.ev));
          chk("err_addr", 36'(err_addr), 36'(e.ea));
          chk("err_src", 36'(err_src), 36'(e.es));
          chk("err_lanes", 36'(err_lanes), 36'(e.el));
        end
      end
    end
  end

  initial begin : driver
    logic [63:0] r64;
    for (int i = 0; i < 128; i++) shadow[i] = '0;
    reset_h = 1; cp_fm_write_h = 0; cp_fm_read_h = 0;
    cp_fm_block = 0; cp_fm_adr = 0; cp_wdata = 0;
    diag_req_h = 0; diag_write_h = 0; diag_addr = 0;
    diag_wdata = 0; scrub_en_h = 0; err_clr_h = 0; inj = 0;
    m_after_rst = 0;
    model_reset();
    quiet(); s_sen = 0;
    s_rst = 1; step(); step();
    ram_init = 0;
    quiet(); step();
    // CP write 3/5 then read it back
    s_w = 1; s_blk = 3; s_adr = 5; s_cwd = 36'o123456654321; step();
    quiet(); s_r = 1; s_blk = 3; s_adr = 5; step();
    quiet(); step(); step();
    // seed 0x10, then diag read starved by CP reads
    s_w = 1; s_blk = 1; s_adr = 0; s_cwd = 36'h9_8765_4321; step();
    quiet(); s_dreq = 1; s_da = 7'h10; s_r = 1; s_blk = 2; s_adr = 7;
    repeat (6) step();
    s_r = 0;
    repeat (14) step();
    s_dreq = 0; step();
    s_dreq = 1; s_dw = 1; s_dwd = 36'h5_a5a5_a5a5;
    repeat (5) step();
    s_dreq = 0; step(); step();
    s_dreq = 1; s_dw = 0; repeat (5) step();
    quiet(); step(); step();
    // scrub sweep with parity faults at 0x2a, 0x2b and 0x30
    s_sen = 1;
    for (int c = 0; c < 5 * 130 + 10; c++) begin
      s_inj = 0; s_clr = 0;
      if (m_psrc == 3) begin
        if (m_paddr == 7'h2A) s_inj = 6'b000100;
        else if (m_paddr == 7'h2B) s_inj = 6'b100000;
        else if (m_paddr == 7'h30) begin
          s_inj = 6'b000011; s_clr = 1;
        end
      end
      step();
    end
    // reset while a diag read sits in WAIT
    quiet(); s_sen = 0; step();
    s_dreq = 1; s_da = 7'h35; step(); step();
    if (m_ph != 2) begin
      errors++; checks++;
      $display("FAIL setup: diag not in WAIT before reset");
    end
    quiet(); s_rst = 1; step();
    quiet(); step(); step();
    // randomized traffic
    s_sen = 1;
    for (int c = 0; c < 2500; c++) begin
      s_w = ($urandom_range(9) < 2);
      s_r = ($urandom_range(9) < 3);
      s_blk = 3'($urandom); s_adr = 4'($urandom);
      r64 = {$urandom, $urandom}; s_cwd = r64[35:0];
      if (m_ph == 0 && !s_dreq && $urandom_range(3) == 0) begin
        s_dreq = 1; s_dw = 1'($urandom); s_da = 7'($urandom);
        r64 = {$urandom, $urandom}; s_dwd = r64[35:0];
      end else if (m_ph == 4 && $urandom_range(2) == 0) s_dreq = 0;
      if ($urandom_range(199) == 0) s_sen = ~s_sen;
      s_clr = ($urandom_range(19) == 0);
      s_inj = ($urandom_range(7) == 0) ? 6'($urandom) : 6'd0;
      step();
    end
    quiet(); step(); step(); step();
    @(negedge clk_h);
    #4;
    chk("drain", 36'(q.size()), 36'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/edp_fm_arb.md
Name: edp_fm_arb

Overview:
- Arbiter and sequencer for the EDP fast-memory (AC block) RAM: 8 blocks × 16 ACs × 36 bits, plus 6 odd-parity bits (one per 6-bit slice).
- Shares the single RAM port between three requesters:
  - microcode (CP): never stalled, always wins;
  - diagnostic read/write: req/ack handshake;
  - background parity scrubber: idle cycles only.
- Generates write parity, checks read parity, and captures the first parity error for the APR/diagnostic logic.

Parameters:
- WORD_W, 36, FM data width.
- LANE_W, 6, bits per parity lane (WORD_W/LANE_W lanes = 6).
- SCRUB_GAP, 16, idle cycles between successive scrub reads (1..255).

Ports:
- clk_h  in  1  system clock
- reset_h  in  1  synchronous, active-high reset
- cp_fm_block  in  3  microcode AC block select
- cp_fm_adr  in  4  microcode AC address
- cp_fm_write_h  in  1  microcode write this cycle
- cp_fm_read_h  in  1  microcode read this cycle
- cp_wdata  in  36  microcode write data
- diag_req_h  in  1  diagnostic request, held until ack
- diag_write_h  in  1  diagnostic op is a write (sampled with req)
- diag_addr  in  7  diagnostic address {block,adr}
- diag_wdata  in  36  diagnostic write data
- diag_ack_h  out  1  one-cycle completion pulse
- diag_rdata  out  36  diagnostic read data, valid with ack
- scrub_en_h  in  1  enable background scrubbing
- err_clr_h  in  1  clear captured error
- fm_addr  out  7  RAM address
- fm_we_h  out  1  RAM write enable
- fm_wdata  out  36  RAM write data
- fm_wpar  out  6  RAM write parity
- fm_rdata  in  36  RAM read data, 1 cycle after address
- fm_rpar  in  6  RAM read parity
- cp_rdata  out  36  microcode read data (registered copy of fm_rdata)
- err_valid_h  out  1  sticky parity-error flag
- err_addr  out  7  address of first error
- err_src  out  2  source of first error (CP/DIAG/SCRUB)
- err_lanes  out  6  failing lanes of first error

Behaviour:
- Reset values:
  - all outputs 0;
  - diag FSM in IDLE;
  - scrub pointer 0, gap counter 0;
  - error registers cleared.
- Address is {block[2:0], adr[3:0]}.
- Write parity: fm_wpar[i] = ~^wdata[6i+5:6i] (odd parity).
- Read check, one cycle after issue: lane i fails if ^{fm_rdata lane i, fm_rpar[i]} == 0.
- Port owner each cycle, in priority order:
  - CP write: CP read is ignored if both are asserted;
  - then CP read;
  - then diag, in ISSUE state;
  - then scrub, when scrub_en_h, gap expired and diag not in ISSUE;
  - else idle, with fm_we_h = 0 and fm_addr holding its last value.
- fm_addr, fm_we_h and fm_wdata are combinational from the winner; the source tag and address are registered one stage for the read check.
- cp_rdata is registered from fm_rdata in the cycle after a CP read, and holds its value otherwise.
- Diag FSM:
  - IDLE → ISSUE on diag_req_h.
  - ISSUE: retries every cycle until it wins the port.
    - Write → ACK.
    - Read → WAIT.
  - WAIT → ACK; the read data is latched into diag_rdata.
  - ACK: diag_ack_h = 1 for exactly one cycle → DONE.
  - DONE → IDLE once diag_req_h = 0, so a held request is not serviced twice.
  - CP traffic may starve diag indefinitely; no timeout.
- Scrub:
  - Gap counter counts idle cycles, saturating at SCRUB_GAP.
  - When the counter is saturated and scrub wins: issue a read of the pointer, pointer += 1 (wraps 127 → 0), gap counter → 0.
  - scrub_en_h = 0 freezes the pointer and clears the gap counter.
- Error capture:
  - The first failing read with err_valid_h = 0 loads err_valid_h, err_addr, err_src and err_lanes.
  - Later errors are ignored until err_clr_h.
  - err_clr_h and a new error in the same cycle: the new error is captured.
- Reset mid-operation: the in-flight read check is discarded, no ack is issued, and the FSM returns to IDLE.

Decomposition:
- Shared package edp_fm_arb_pkg holds:
  - the fm_src_t enum (SRC_NONE = 0, SRC_CP = 1, SRC_DIAG = 2, SRC_SCRUB = 3);
  - FM_WORDS = 128, FM_AW = 7, LANES = 6;
  - the diag state enum.
- One sub-module, edp_fm_par: pure combinational 6-lane odd-parity generator and checker, instantiated twice (write generate, read check).

Test Plan:
- CP write to block 3 AC 5, data 0o123456_654321 → fm_addr = 0x35, fm_we_h = 1, correct fm_wpar; a CP read next cycle → cp_rdata equals that data one cycle later, err_valid_h stays 0.
- Diag read of 0x10 while CP reads continuously for 5 cycles → diag stays in ISSUE; it is granted on the first CP-idle cycle, then diag_ack_h pulses exactly once, 2 cycles after the grant, with the correct diag_rdata.
- diag_req_h held high for 10 cycles after ack → no second access; req low then high again → a new access.
- scrub_en_h = 1, SCRUB_GAP = 4, no other traffic → scrub reads at addresses 0, 1, 2 …, 5 cycles apart, wrapping 127 → 0.
- Flip fm_rpar[2] on a scrub read of 0x2A → err_valid_h = 1, err_addr = 0x2A, err_src = SRC_SCRUB, err_lanes = 6'b000100; a second error leaves these unchanged; err_clr_h with a simultaneous new error captures the new error.
- Assert reset_h during diag WAIT → no ack, FSM in IDLE, all outputs 0 on the next cycle.
